// File: rtl/sha_stream_io_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sha_io_pkg
// Shared definitions for the SHA-256 host-side stream I/O controller:
//   - controller state encoding
//   - default bus / block / digest widths
//   - beat-index to lane-index mapping used for loading and unloading
// No ports (package).
// -----------------------------------------------------------------------------
package sha_io_pkg;

  localparam int SHA_BUS_W    = 8;
  localparam int SHA_BLOCK_W  = 512;
  localparam int SHA_DIGEST_W = 256;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } sha_io_state_e;

  // Beat k lands in lane n_lanes-1-k when the stream is big-endian (first beat
  // is the most significant lane), otherwise in lane k.
  function automatic int lane_index(input int beat, input int n_lanes, input bit msb_first);
    return msb_first ? (n_lanes - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/sha_stream_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// sha_stream_io_ctrl_if
// Byte-stream bundle between the pin wrapper (master) and the controller
// (slave).
//   in_valid / in_data / in_ready    : message beats into the controller
//   out_valid / out_data / out_ready : digest beats out of the controller
// -----------------------------------------------------------------------------
interface sha_stream_io_ctrl_if
  import sha_io_pkg::*;
#(
  parameter int BUS_W = SHA_BUS_W
);

  logic             in_valid;
  logic [BUS_W-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [BUS_W-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sha_lane_mux.sv
// -----------------------------------------------------------------------------
// sha_lane_mux
// Combinational read of one LANE_W-bit lane out of a VEC_W-bit vector.
// Lane j occupies bits [j*LANE_W +: LANE_W].
//   vec  : wide source vector
//   lane : lane select
//   data : selected lane
// -----------------------------------------------------------------------------
module sha_lane_mux
  import sha_io_pkg::*;
#(
  parameter int VEC_W  = SHA_DIGEST_W,
  parameter int LANE_W = SHA_BUS_W,
  localparam int N_LANES = VEC_W / LANE_W,
  localparam int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic [VEC_W-1:0]  vec,
  input  logic [IDX_W-1:0]  lane,
  output logic [LANE_W-1:0] data
);

  // Table is padded to a power of two so every select value is in range.
  logic [LANE_W-1:0] lanes [2**IDX_W];

  generate
    for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_lane
      if (gi < N_LANES) begin : g_used
        assign lanes[gi] = vec[gi*LANE_W +: LANE_W];
      end else begin : g_pad
        assign lanes[gi] = '0;
      end
    end
  endgenerate

  assign data = lanes[lane];

endmodule

// File: rtl/sha_stream_io_ctrl.sv
// -----------------------------------------------------------------------------
// sha_stream_io_ctrl
// Host-side I/O controller for the SHA-256 core. Collects one message block
// from a valid/ready beat stream, pulses the core start, waits for the digest
// (with optional timeout), then streams the digest back out beat by beat.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear_i        : synchronous abort back to LOAD
//   io (slave)     : in_valid/in_data/in_ready, out_valid/out_data/out_ready
//   blk_o          : assembled message block to the core
//   start_o        : one-cycle start pulse to the core
//   core_ready_i   : core digest valid (sampled only while waiting)
//   digest_i       : core digest
//   busy_o         : high while starting or waiting on the core
//   done_o         : one-cycle pulse after the last digest beat is taken
//   err_o          : sticky timeout flag
// -----------------------------------------------------------------------------
module sha_stream_io_ctrl
  import sha_io_pkg::*;
#(
  parameter int BUS_W       = SHA_BUS_W,
  parameter int BLOCK_W     = SHA_BLOCK_W,
  parameter int DIGEST_W    = SHA_DIGEST_W,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  sha_stream_io_ctrl_if.slave io,
  output logic [BLOCK_W-1:0]  blk_o,
  output logic                start_o,
  input  logic                core_ready_i,
  input  logic [DIGEST_W-1:0] digest_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int N_IN      = BLOCK_W / BUS_W;
  localparam int N_OUT     = DIGEST_W / BUS_W;
  localparam int N_MAX     = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int PTR_W     = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int OUT_IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int CNT_W     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

  localparam logic [PTR_W-1:0] PTR_LAST_IN  = PTR_W'(N_IN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST_OUT = PTR_W'(N_OUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  sha_io_state_e       state_reg;
  logic [PTR_W-1:0]    ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [BLOCK_W-1:0]  blk_reg;
  logic [DIGEST_W-1:0] digest_reg;
  logic                start_reg;
  logic                done_reg;
  logic                err_reg;

  logic                 in_hs;
  logic [PTR_W-1:0]     in_lane;
  logic [N_IN-1:0]      in_we;
  logic [OUT_IDX_W-1:0] out_lane;
  logic [BUS_W-1:0]     out_lane_data;

  assign in_hs   = io.in_valid && (state_reg == S_LOAD);
  assign in_lane = PTR_W'(lane_index(int'(ptr_reg), N_IN, MSB_FIRST));

  // One write enable per block lane; only the lane addressed by ptr is hit.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_we
      assign in_we[gi] = in_hs && (in_lane == PTR_W'(gi));
    end
  endgenerate

  assign out_lane = OUT_IDX_W'(lane_index(int'(ptr_reg), N_OUT, MSB_FIRST));

  sha_lane_mux #(
    .VEC_W  (DIGEST_W),
    .LANE_W (BUS_W)
  ) u_out_mux (
    .vec  (digest_reg),
    .lane (out_lane),
    .data (out_lane_data)
  );

  // Stream-side outputs follow the state register directly; the data lane is
  // forced to zero outside UNLOAD so a stale pointer never leaks digest bits.
  assign io.in_ready  = (state_reg == S_LOAD);
  assign io.out_valid = (state_reg == S_UNLOAD);
  assign io.out_data  = (state_reg == S_UNLOAD) ? out_lane_data : '0;

  assign blk_o   = blk_reg;
  assign start_o = start_reg;
  assign done_o  = done_reg;
  assign err_o   = err_reg;
  assign busy_o  = (state_reg == S_START) || (state_reg == S_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_LOAD;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      blk_reg    <= '0;
      digest_reg <= '0;
      start_reg  <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else if (clear_i) begin
      // Abort wins over any handshake in the same cycle; that beat is lost.
      state_reg <= S_LOAD;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      blk_reg   <= '0;
      start_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        S_LOAD: begin
          for (int j = 0; j < N_IN; j++) begin
            if (in_we[j]) begin
              blk_reg[j*BUS_W +: BUS_W] <= io.in_data;
            end
          end
          if (in_hs) begin
            if (ptr_reg == PTR_LAST_IN) begin
              ptr_reg   <= '0;
              state_reg <= S_START;
              start_reg <= 1'b1;
            end else begin
              ptr_reg <= ptr_reg + 1'b1;
            end
          end
        end
        S_START: begin
          state_reg <= S_WAIT;
          cnt_reg   <= '0;
        end
        S_WAIT: begin
          // A digest arriving on the timeout cycle is still accepted.
          if (core_ready_i) begin
            digest_reg <= digest_i;
            ptr_reg    <= '0;
            state_reg  <= S_UNLOAD;
          end else if (TIMEOUT_EN && (cnt_reg == CNT_LAST)) begin
            err_reg   <= 1'b1;
            ptr_reg   <= '0;
            state_reg <= S_LOAD;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (io.out_ready) begin
            if (ptr_reg == PTR_LAST_OUT) begin
              ptr_reg   <= '0;
              done_reg  <= 1'b1;
              state_reg <= S_LOAD;
            end else begin
              ptr_reg <= ptr_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= S_LOAD;
          ptr_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_stream_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha_stream_io_ctrl
// Two controllers share one stimulus: dut_a is big-endian with a 16-cycle
// timeout, dut_b is little-endian with the timeout disabled. Digest beats are
// queued when the core responds and popped as the consumer accepts them.
// -----------------------------------------------------------------------------
module tb_sha_stream_io_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear_i;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         out_ready;
  logic         core_ready;
  logic [255:0] digest;

  logic [511:0] blk_a, blk_b;
  logic start_a, start_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [7:0] tx [64];

  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ALT =
    256'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'd24};

  always #5 clk = ~clk;

  sha_stream_io_ctrl_if #(.BUS_W(8)) if_a ();
  sha_stream_io_ctrl_if #(.BUS_W(8)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_data   = in_data;
  assign if_b.out_ready = out_ready;

  sha_stream_io_ctrl #(
    .BUS_W(8), .BLOCK_W(512), .DIGEST_W(256), .MSB_FIRST(1'b1), .TIMEOUT_CYC(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .io(if_a),
    .blk_o(blk_a), .start_o(start_a), .core_ready_i(core_ready), .digest_i(digest),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
  );

  sha_stream_io_ctrl #(
    .BUS_W(8), .BLOCK_W(512), .DIGEST_W(256), .MSB_FIRST(1'b0), .TIMEOUT_CYC(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .io(if_b),
    .blk_o(blk_b), .start_o(start_b), .core_ready_i(core_ready), .digest_i(digest),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pack_msb();
    logic [511:0] r = '0;
    for (int k = 0; k < 64; k++) r[511-8*k -: 8] = tx[k];
    return r;
  endfunction

  function automatic logic [511:0] pack_lsb();
    logic [511:0] r = '0;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = tx[k];
    return r;
  endfunction

  task automatic load_abc();
    logic [511:0] b = ABC_BLK;
    for (int k = 0; k < 64; k++) tx[k] = b[511-8*k -: 8];
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_in_ready"}, if_a.in_ready, 1);
    check({p, "_out_valid"}, if_a.out_valid, 0);
    check({p, "_out_data"}, if_a.out_data, 0);
    check({p, "_blk"}, blk_a, 0);
    check({p, "_start"}, start_a, 0);
    check({p, "_done"}, done_a, 0);
    check({p, "_err"}, err_a, 0);
    check({p, "_busy"}, busy_a, 0);
    check({p, "_blk_b"}, blk_b, 0);
    check({p, "_err_b"}, err_b, 0);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    check("clear_blk", blk_a, 0);
    check("clear_err", err_a, 0);
    check("clear_in_ready", if_a.in_ready, 1);
  endtask

  // Streams tx[0..n-1]; returns on the negedge after the last beat is taken.
  task automatic send_block(input bit gaps, input int n);
    int k = 0;
    int cyc = 0;
    int starts = 0;
    while (k < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (start_a) starts++;
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'hxx;
      end else begin
        in_valid = 1'b1;
        in_data  = tx[k];
      end
      if (in_valid && if_a.in_ready) k++;
    end
    check("send_beats", k, n);
    check("send_no_early_start", starts, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the negedge where start_o is seen; answers after 'delay' cycles.
  task automatic wait_core(input int delay, input logic [255:0] dig);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("wait_start_low", start_a, 0);
        check("wait_busy", busy_a, 1);
        check("wait_busy_b", busy_b, 1);
        check("wait_in_ready", if_a.in_ready, 0);
      end
    end
    core_ready = 1'b1;
    digest     = dig;
    for (int k = 0; k < 32; k++) begin
      q_a.push_back(dig[255-8*k -: 8]);
      q_b.push_back(dig[8*k +: 8]);
    end
    @(negedge clk);
    core_ready = 1'b0;
    digest     = ~dig;
    check("out_valid_lat", if_a.out_valid, 1);
    check("busy_after_core", busy_a, 0);
  endtask

  task automatic receive(input int n, input bit stalls);
    int got = 0;
    int cyc = 0;
    int dones = 0;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_a) dones++;
      if (if_a.out_valid) begin
        if (q_a.size() == 0 || q_b.size() == 0) begin
          check("rx_queue_empty", 1, 0);
        end else begin
          check($sformatf("rx_a_beat%0d", got), if_a.out_data, q_a[0]);
          check($sformatf("rx_b_beat%0d", got), {if_b.out_valid, if_b.out_data}, {1'b1, q_b[0]});
          if (out_ready) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
            got++;
          end
        end
      end
    end
    check("rx_beats", got, n);
    if (n == 32) begin
      check("rx_no_early_done", dones, 0);
      @(negedge clk);
      out_ready = 1'b0;
      check("rx_done_pulse", {done_a, done_b}, 2'b11);
      check("rx_out_valid_off", if_a.out_valid, 0);
      check("rx_back_to_load", if_a.in_ready, 1);
      @(negedge clk);
      check("rx_done_once", done_a, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    clear_i    = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b0;
    core_ready = 1'b0;
    digest     = '0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: "abc" block, continuous valid, no stalls.
    load_abc();
    send_block(1'b0, 64);
    check("t1_start", start_a, 1);
    check("t1_blk", blk_a, ABC_BLK);
    check("t1_blk_word0", blk_a[511:480], 32'h61626380);
    check("t1_blk_b", blk_b, pack_lsb());
    wait_core(3, D_ABC);
    check("t1_beat0", if_a.out_data, 8'hba);
    receive(32, 1'b0);
    $display("t1 abc stream complete, checks=%0d", checks);

    // 2: same data with input gaps and output stalls.
    clear_pulse();
    send_block(1'b1, 64);
    check("t2_start", start_a, 1);
    check("t2_blk", blk_a, ABC_BLK);
    wait_core(5, D_ABC);
    receive(32, 1'b1);
    $display("t2 gapped stream complete, checks=%0d", checks);

    // 3: beat k carries value k; dut_b is little-endian.
    for (int k = 0; k < 64; k++) tx[k] = 8'(k);
    send_block(1'b0, 64);
    check("t3_start_b", start_b, 1);
    check("t3_blk_b", blk_b, pack_lsb());
    check("t3_blk_b_lo", blk_b[7:0], 8'h00);
    check("t3_blk_b_hi", blk_b[511:504], 8'h3f);
    check("t3_blk_a", blk_a, pack_msb());
    wait_core(2, D_ALT);
    check("t3_b_beat0", if_b.out_data, 8'hf0);
    receive(32, 1'b0);
    $display("t3 lsb-first stream complete, checks=%0d", checks);

    // 4: core never answers; dut_a times out after 16 WAIT cycles.
    load_abc();
    send_block(1'b0, 64);
    check("t4_start", start_a, 1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) check("t4_err_not_yet", err_a, 0);
    end
    @(negedge clk);
    check("t4_err", err_a, 1);
    check("t4_in_ready", if_a.in_ready, 1);
    check("t4_busy", busy_a, 0);
    check("t4_no_out", if_a.out_valid, 0);
    send_block(1'b0, 64);
    check("t4_reload_start", start_a, 1);
    check("t4_reload_blk", blk_a, ABC_BLK);
    wait_core(3, D_ABC);
    receive(32, 1'b0);
    check("t4_err_sticky", err_a, 1);
    $display("t4 timeout and reload complete, checks=%0d", checks);

    // 5: clear on beat 30 drops the partial block and the sticky error.
    for (int k = 0; k < 64; k++) tx[k] = 8'hA5 ^ 8'(k);
    send_block(1'b0, 30);
    in_valid = 1'b1;
    in_data  = 8'hee;
    clear_i  = 1'b1;
    @(negedge clk);
    clear_i  = 1'b0;
    in_valid = 1'b0;
    check("t5_blk_cleared", blk_a, 0);
    check("t5_err_cleared", err_a, 0);
    load_abc();
    send_block(1'b0, 64);
    check("t5_start", start_a, 1);
    check("t5_blk_new_only", blk_a, ABC_BLK);
    wait_core(4, D_ABC);
    receive(32, 1'b0);
    $display("t5 clear mid-load complete, checks=%0d", checks);

    // 6a: core_ready on the timeout cycle wins.
    send_block(1'b0, 64);
    check("t6_start", start_a, 1);
    wait_core(16, D_ALT);
    check("t6_race_err", err_a, 0);
    receive(32, 1'b0);
    $display("t6a ready/timeout race complete, checks=%0d", checks);

    // 6b: reset during UNLOAD after 10 digest beats.
    send_block(1'b0, 64);
    wait_core(3, D_ABC);
    receive(10, 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_vals("t6_reset");
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_block(1'b0, 64);
    check("t6_after_start", start_a, 1);
    check("t6_after_blk", blk_a, ABC_BLK);
    wait_core(3, D_ABC);
    receive(32, 1'b0);
    $display("t6b reset mid-unload complete, checks=%0d", checks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
